// File: rtl/move_best_select.sv
// Scans the all_moves list and keeps the best move: max eval for white, min eval for black.
// Optional MOVE_SELECT_AUTO_CLEAR_EN: pulse am_clear_moves after sel_done and hold off re-arm.
module move_best_select #(
  parameter int unsigned MAX_POSITIONS_LOG2 = 8,
  parameter int unsigned EVAL_WIDTH         = 24,
  parameter int unsigned UCI_WIDTH          = 16,
  parameter int unsigned RAM_LATENCY        = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          am_moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
  input  logic                          white_to_move_in,
  input  logic [EVAL_WIDTH-1:0]         initial_eval_in,
  input  logic [EVAL_WIDTH-1:0]         eval_in,
  input  logic [UCI_WIDTH-1:0]          uci_in,
  output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
  output logic                          am_clear_moves,
  output logic                          busy,
  output logic                          sel_done,
  output logic                          no_moves,
  output logic [MAX_POSITIONS_LOG2-1:0] best_index,
  output logic [UCI_WIDTH-1:0]          best_uci,
  output logic [EVAL_WIDTH-1:0]         best_eval
);

  localparam int unsigned IDX_W = MAX_POSITIONS_LOG2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMPARE,
    ST_DONE,
    ST_CLEAR
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   count_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   wait_q;
  logic               white_q;
  logic               armed_q;
  logic               busy_q;
  logic               done_q;
  logic               no_moves_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [UCI_WIDTH-1:0]  best_uci_q;
  logic [EVAL_WIDTH-1:0] best_eval_q;

  logic better_c;
  logic last_c;
  logic holdoff_c;
  logic start_c;

  assign better_c = white_q ? ($signed(eval_in) > $signed(best_eval_q))
                            : ($signed(eval_in) < $signed(best_eval_q));
  assign last_c   = (idx_q == (count_q - IDX_W'(1)));
  assign start_c  = (state_q == ST_IDLE) && am_moves_ready && armed_q && !holdoff_c;

`ifdef MOVE_SELECT_AUTO_CLEAR_EN
  logic       clear_q;
  logic [1:0] holdoff_q;

  // Give all_moves two cycles to drop its ready after being cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdoff_q <= 2'd0;
    end else if (state_q == ST_CLEAR) begin
      holdoff_q <= 2'd2;
    end else if ((state_q == ST_IDLE) && (holdoff_q != 2'd0)) begin
      holdoff_q <= holdoff_q - 2'd1;
    end
  end

  assign holdoff_c      = (holdoff_q != 2'd0);
  assign am_clear_moves = clear_q;
`else
  assign holdoff_c      = 1'b0;
  assign am_clear_moves = 1'b0;
`endif

  // Scan FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      white_q     <= 1'b0;
      armed_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      no_moves_q  <= 1'b0;
      best_idx_q  <= '0;
      best_uci_q  <= '0;
      best_eval_q <= '0;
`ifdef MOVE_SELECT_AUTO_CLEAR_EN
      clear_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MOVE_SELECT_AUTO_CLEAR_EN
      clear_q <= 1'b0;
`endif
      // A new scan needs ready to have been seen low since the last start.
      if (!am_moves_ready) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            armed_q <= 1'b0;
            count_q <= am_move_count;
            white_q <= white_to_move_in;
            idx_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b1;
            if (am_move_count == IDX_W'(0)) begin
              state_q     <= ST_DONE;
              no_moves_q  <= 1'b1;
              best_idx_q  <= '0;
              best_uci_q  <= '0;
              best_eval_q <= initial_eval_in;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (wait_q == CNT_W'(RAM_LATENCY - 1)) begin
            state_q <= ST_COMPARE;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end

        ST_COMPARE: begin
          no_moves_q <= 1'b0;
          if ((idx_q == IDX_W'(0)) || better_c) begin
            best_idx_q  <= idx_q;
            best_uci_q  <= uci_in;
            best_eval_q <= eval_in;
          end
          if (last_c) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            wait_q  <= '0;
            state_q <= ST_WAIT;
          end
        end

        ST_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
`ifdef MOVE_SELECT_AUTO_CLEAR_EN
          state_q <= ST_CLEAR;
`else
          state_q <= ST_IDLE;
`endif
        end

`ifdef MOVE_SELECT_AUTO_CLEAR_EN
        ST_CLEAR: begin
          clear_q <= 1'b1;
          state_q <= ST_IDLE;
        end
`endif

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign am_move_index = idx_q;
  assign busy          = busy_q;
  assign sel_done      = done_q;
  assign no_moves      = no_moves_q;
  assign best_index    = best_idx_q;
  assign best_uci      = best_uci_q;
  assign best_eval     = best_eval_q;

endmodule

// File: doc/move_best_select.md
Name: move_best_select

Overview:
- Sits directly downstream of all_moves and consumes the move list it has generated.
- Once all_moves reports moves ready, the block walks am_move_index from 0 to am_move_count-1. For each index it waits out the move-RAM read latency, then samples eval_out and uci_out.
- It keeps the best move: maximum eval when white is to move, minimum eval when black is to move. It reports index, UCI and eval with a done pulse, for the one-ply search controller and the UCI front end.

Parameters:
MAX_POSITIONS_LOG2, 8, width of move index and move count
EVAL_WIDTH, 24, width of signed evaluation
UCI_WIDTH, 16, packed move width {promotion[3:0], to[5:0], from[5:0]}
RAM_LATENCY, 2, cycles from am_move_index change to valid eval_in/uci_in (legal range 1..7)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
am_moves_ready  in  1  all_moves list complete; level, sampled in IDLE only
am_move_count  in  MAX_POSITIONS_LOG2  number of legal moves
white_to_move_in  in  1  side to move in root position; 1 = maximise
initial_eval_in  in  EVAL_WIDTH  signed root eval, reported when there are no moves
eval_in  in  EVAL_WIDTH  signed eval_out of the indexed move
uci_in  in  UCI_WIDTH  uci_out of the indexed move
am_move_index  out  MAX_POSITIONS_LOG2  move RAM read index
am_clear_moves  out  1  one-cycle pulse telling all_moves to reset its list
busy  out  1  scan in progress
sel_done  out  1  one-cycle pulse, result valid
no_moves  out  1  count was 0 at start; held with result
best_index  out  MAX_POSITIONS_LOG2  index of selected move
best_uci  out  UCI_WIDTH  UCI of selected move
best_eval  out  EVAL_WIDTH  signed eval of selected move

Behaviour:
- Reset (asynchronous, active-high) forces every output to 0 and the state to IDLE. It may be asserted mid-scan: the scan is abandoned and no sel_done is issued.
- IDLE:
  - If am_moves_ready=1, latch count and side to move, set am_move_index=0, busy=1, and go to WAIT.
  - If the latched count is 0, instead go to DONE with no_moves=1, best_eval=initial_eval_in, best_index=0 and best_uci=0.
- WAIT: a counter runs for RAM_LATENCY cycles after the index update, then the state moves to COMPARE.
- COMPARE:
  - Sample eval_in and uci_in. Index 0 always loads the best registers.
  - Any later index replaces the best only on a strictly better eval: signed greater than for white, signed less than for black. Ties keep the lowest index.
  - If index == count-1, go to DONE; otherwise increment the index and return to WAIT.
- DONE:
  - sel_done=1 for exactly one cycle, busy=0, then return to IDLE.
  - best_* and no_moves hold until the next scan starts; at scan start they are not cleared until the first COMPARE.
- Per-move latency is RAM_LATENCY+1 cycles. Total latency from am_moves_ready sampled to sel_done is count*(RAM_LATENCY+1)+1 cycles.
- am_moves_ready is ignored while busy. A scan must not restart while am_moves_ready stays high after DONE: re-arming requires am_moves_ready to deassert (it is cleared by am_clear_moves or by the controller).
- Comparisons use $signed over the full EVAL_WIDTH, with no saturation. A count of 2**MAX_POSITIONS_LOG2-1 must scan without index wrap.
- am_clear_moves stays 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: MOVE_SELECT_AUTO_CLEAR_EN.
- Defined: am_clear_moves pulses for one cycle in the cycle after sel_done. IDLE then ignores am_moves_ready for 2 cycles, covering the all_moves reset wait.
- Undefined: am_clear_moves is tied to 0 and the controller clears all_moves externally.

Test Plan:
- White to move, count=4, evals {10,-5,30,30}, RAM_LATENCY=2 -> sel_done at cycle 13 after start; best_index=2, best_eval=30, best_uci=uci[2]; tie with index 3 keeps index 2.
- Black to move, count=3, evals {100,-200,-200} -> best_index=1, best_eval=-200, no_moves=0.
- count=0, initial_eval_in=-8388608 (checkmate) -> sel_done 1 cycle after start, no_moves=1, best_eval=-8388608, am_move_index stays 0.
- Reset asserted during WAIT at index 5 of 10 -> all outputs 0 immediately, no sel_done. A fresh start after reset scans from index 0.
- am_moves_ready held high across DONE, with the macro undefined -> no second scan until it drops and rises again. With MOVE_SELECT_AUTO_CLEAR_EN defined -> am_clear_moves high exactly the cycle after sel_done.
- count=1, eval=+8388607 (white) -> best_index=0, best_eval=8388607; am_move_index never exceeds 0.
